// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the digit-serial adder.
// Holds the FSM state encoding and the digit-counter width calculation.
package serial_adder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int cnt_width(input int width, input int digit);
        int n;
        n = width / digit;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Building block for the ripple digit adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_digit.sv
// Combinational DIGIT-bit ripple adder built from full_adder cells.
// Also exposes the carry into the MSB for overflow detection.
module digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract: one DIGIT-bit slice per cycle, LSB first.
// Results land on the edge that raises done and hold until the next one.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("serial_adder: WIDTH must be a multiple of DIGIT");
    end

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             sub_q;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             run;
    logic             last;
    logic             accept;

    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [DIGIT-1:0] b_slice;
    logic [DIGIT-1:0] s_slice;
    logic             c_out;
    logic             c_msb;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        run  = (state == RUN);
        busy = run;
    end

    assign last   = run && (cnt == LAST);
    assign accept = (state == IDLE) && start;

    // Subtraction feeds ~B with an initial carry of 1.
    assign b_slice = b_q[DIGIT-1:0] ^ {DIGIT{sub_q}};

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a     (a_q[DIGIT-1:0]),
        .b     (b_slice),
        .cin   (carry_q),
        .sum   (s_slice),
        .cout  (c_out),
        .c_msb (c_msb)
    );

    assign acc_next = (acc >> DIGIT) | (WIDTH'(s_slice) << (WIDTH - DIGIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            acc     <= '0;
            sub_q   <= sub;
            carry_q <= sub | cin;
            cnt     <= '0;
        end else if (run) begin
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            acc     <= acc_next;
            carry_q <= c_out;
            cnt     <= last ? '0 : cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= last;
            if (last) begin
                sum_q  <= acc_next;
                cout_q <= c_out;
                ovf_q  <= c_out ^ c_msb;
            end
        end
    end

    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed cases plus random add/sub against
// an arithmetic reference, with DIGIT=1 and DIGIT=WIDTH variants.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;

    logic        busy4, done4, cout4, ovf4;
    logic [15:0] sum4;
    logic        busy1, done1, cout1, ovf1;
    logic [15:0] sum1;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(16), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .cin(cin), .sub(sub), .busy(busy4), .done(done4),
        .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    serial_adder #(.WIDTH(16), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .cin(cin), .sub(sub), .busy(busy1), .done(done1),
        .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    serial_adder #(.WIDTH(16), .DIGIT(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .cin(cin), .sub(sub), .busy(busy16), .done(done16),
        .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    // Reference: {ovf, cout, sum} from integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic ci,
                                          input logic s);
        int ux, uy, ur, sx, sy, sr;
        logic co, ov;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            ur = ux - uy;
            co = (ux >= uy);
            sr = sx - sy;
        end else begin
            ur = ux + uy + int'(ci);
            co = (ur > 65535);
            sr = sx + sy + int'(ci);
        end
        ov = (sr > 32767) || (sr < -32768);
        return {ov, co, ur[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op (called while dut4 is idle or in its done cycle).
    task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                          input logic ci, input logic s, input bit poke);
        int lat;
        logic [17:0] exp;
        exp = model(x, y, ci, s);
        a = x; b = y; cin = ci; sub = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        while (lat < 40) begin
            if (poke && lat == 1) begin
                start = 1'b1; a = ~x; b = x; sub = ~s;
            end
            @(posedge clk); #1;
            lat++;
            start = 1'b0;
            if (done4) break;
        end
        chk("latency", lat, 4);
        chk("sum", sum4, exp[15:0]);
        chk("cout", cout4, exp[16]);
        chk("ovf", ovf4, exp[17]);
    endtask

    initial begin
        int dn, l1, l16;
        rst_n = 1'b0; start = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        @(posedge clk); #1;
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_sum", sum4, 0);
        chk("rst_cout", cout4, 0);
        chk("rst_ovf", ovf4, 0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
        chk("basic_sum", sum4, 16'h5555);
        chk("basic_cout", cout4, 0);
        chk("basic_ovf", ovf4, 0);

        @(posedge clk); #1;
        chk("done_pulse", done4, 0);
        chk("busy_idle", busy4, 0);
        chk("sum_hold", sum4, 16'h5555);

        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        chk("wrap_sum", sum4, 16'h0000);
        chk("wrap_cout", cout4, 1);
        chk("wrap_ovf", ovf4, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        chk("ovf_sum", sum4, 16'h8000);
        chk("ovf_cout", cout4, 0);
        chk("ovf_ovf", ovf4, 1);
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
        chk("sub_sum", sum4, 16'hFFFE);
        chk("sub_cout", cout4, 0);
        chk("sub_ovf", ovf4, 0);

        // Start pulsed mid-run is ignored; following ops are back-to-back.
        run_op(16'h00FF, 16'h0101, 1'b0, 1'b0, 1'b1);
        chk("poke_sum", sum4, 16'h0200);
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
        chk("b2b_sum", sum4, 16'h0000);
        chk("b2b_ovf", ovf4, 1);

        for (int i = 0; i < 40; i++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom),
                   1'($urandom), bit'(i % 5 == 0));

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);

        // Reset in RUN cycle 2 aborts the operation.
        a = 16'h0F0F; b = 16'h0101; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy4, 0);
        chk("abort_done", done4, 0);
        chk("abort_sum", sum4, 0);
        chk("abort_cout", cout4, 0);
        chk("abort_ovf", ovf4, 0);
        dn = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (c == 1) rst_n = 1'b1;
            if (done4) dn++;
        end
        chk("abort_no_done", dn, 0);

        // All three widths take the same op from idle.
        a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        l1 = 0; l16 = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done1 && l1 == 0) l1 = c;
            if (done16 && l16 == 0) l16 = c;
        end
        chk("d1_latency", l1, 16);
        chk("d1_sum", sum1, 16'h5555);
        chk("d1_cout", cout1, 0);
        chk("d1_ovf", ovf1, 0);
        chk("d16_latency", l16, 1);
        chk("d16_sum", sum16, 16'h5555);
        chk("d16_cout", cout16, 0);
        chk("d16_ovf", ovf16, 0);
        chk("d4_sum", sum4, 16'h5555);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the operand and sum width in bits.
REQ-002 The module SHALL have parameter DIGIT, default 4, giving the bits added per clock cycle; WIDTH % DIGIT == 0 SHALL hold.
REQ-003 The module SHALL have one clock and one reset; reset SHALL be asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request to begin an operation; sampled only when busy is low.
REQ-007 a  input  WIDTH  operand A; captured when start is accepted.
REQ-008 b  input  WIDTH  operand B; captured when start is accepted.
REQ-009 cin  input  1  carry-in; captured when start is accepted; ignored when sub=1.
REQ-010 sub  input  1  mode: 0 = A+B+cin, 1 = A-B (A + ~B + 1); captured when start is accepted.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle pulse marking that sum, cout and ovf are updated.
REQ-013 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 cout  output  1  carry out of the MSB; in subtract mode 1 = no borrow.
REQ-015 ovf  output  1  two's-complement signed overflow of the result.

Function
REQ-016 The FSM SHALL have states IDLE and RUN; busy SHALL equal (state == RUN).
REQ-017 IDLE->RUN SHALL occur at a rising edge with start=1 in IDLE; operands, mode and initial carry (sub ? 1 : cin) SHALL be latched on that edge; the digit counter SHALL be cleared.
REQ-018 Each RUN cycle SHALL add one DIGIT-bit slice, LSB slice first, using the registered carry; the slice carry-out SHALL be registered for the next slice.
REQ-019 With N = WIDTH/DIGIT, done SHALL be high exactly N cycles after the accepting edge, for one cycle; RUN->IDLE SHALL occur on that same edge.
REQ-020 sum, cout and ovf SHALL update only on the edge that raises done and SHALL hold until the next done or reset.
REQ-021 ovf SHALL be 1 iff the MSBs of A and of the effective B (B or ~B) are equal and the sum MSB differs from them.
REQ-022 start while busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-023 start=1 in the cycle where done=1 SHALL be accepted (state is IDLE), giving back-to-back operations with no idle gap.
REQ-024 Input changes on a, b, cin and sub after the accepting edge SHALL NOT affect the result.
REQ-025 DIGIT == WIDTH SHALL be legal and give N=1; DIGIT=1 SHALL be legal and give N=WIDTH.

Reset
REQ-026 rst_n low SHALL force, asynchronously: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, and all operand, carry and counter registers to 0.
REQ-027 Reset during RUN SHALL abort the operation; no done SHALL be produced for it.
REQ-028 After rst_n deasserts, start SHALL be accepted at the first rising edge.

Structure
REQ-029 Package serial_adder_pkg SHALL hold the FSM state typedef (IDLE, RUN) and a function computing the counter width, $clog2(WIDTH/DIGIT) with a minimum of 1.
REQ-030 Sub-module digit_adder (combinational DIGIT-bit ripple of the team's full_adder cells, outputs: slice sum, carry-out, carry into the MSB) SHALL be instantiated once.
REQ-031 An elaboration-time check SHALL flag WIDTH % DIGIT != 0.

Verification (WIDTH=16, DIGIT=4, N=4 unless stated)
REQ-032 a=0x1234, b=0x4321, cin=0, sub=0 -> done 4 cycles after accept; sum=0x5555, cout=0, ovf=0.
REQ-033 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-034 sub=1, a=0x0005, b=0x0007, cin=1 -> sum=0xFFFE, cout=0, ovf=0 (cin ignored).
REQ-035 start pulsed during RUN with different operands -> ignored, original result returned; start held during the done cycle -> second op accepted, done again 4 cycles later.
REQ-036 rst_n low in RUN cycle 2 -> all outputs 0 immediately, no done; repeat REQ-032 with DIGIT=1 (latency 16) and DIGIT=16 (latency 1) -> same results.
